csa_stream_accumulator: RTL and testbench
=========================================

Name: csa_stream_accumulator

Overview:
- Sequential consumer for the 3:2 carry-save stage. Accepts a stream of WIDTH-bit unsigned operands over a valid/ready handshake.
- Accumulates them in redundant sum/carry registers, using one carry-save compression per accepted operand.
- After the last operand, resolves the redundant pair to a binary result by iterated half-add (carry-propagate) passes.
- Presents the result on an output valid/ready handshake. Used wherever many operands must be summed without a full carry chain per operand.

Parameters:
- WIDTH, 4, operand width in bits.
- ACC_WIDTH, 8, accumulator/result width in bits; must be >= WIDTH.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand present.
- in_ready  output  1  block can accept an operand.
- in_data  input  WIDTH  operand, zero-extended to ACC_WIDTH.
- in_last  input  1  qualifies in_data as the final operand of the group.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- out_sum  output  ACC_WIDTH  resolved sum modulo 2^ACC_WIDTH.
- out_overflow  output  1  true sum exceeded 2^ACC_WIDTH - 1.

Behaviour:
- Clocking: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: state=ACCUM, S=0, C=0, ovf=0. Outputs: in_ready=1, out_valid=0, out_sum=0, out_overflow=0.
- Internal registers: S and C are ACC_WIDTH bits. C is stored already left-shifted (weight-aligned). ovf is a sticky flag.
- States:
  - ACCUM: in_ready=1, out_valid=0.
  - RESOLVE: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- ACCUM, on in_valid && in_ready, with X = zero-extended in_data:
  - S <= S ^ C ^ X.
  - M = majority(S, C, X).
  - C <= M << 1, truncated to ACC_WIDTH.
  - ovf <= ovf | M[ACC_WIDTH-1].
  - If in_last is set in the same beat, next state is RESOLVE.
- ACCUM, without acceptance: registers hold.
- RESOLVE, each cycle:
  - If C == 0: next state DONE, registers hold.
  - Else: S <= S ^ C; C <= (S & C) << 1; ovf <= ovf | (S & C)[ACC_WIDTH-1].
  - Terminates within ACC_WIDTH iteration cycles plus the final C==0 check cycle.
- Latency: the in_last beat is accepted at edge k. out_valid is asserted no earlier than edge k+2, and no later than edge k+ACC_WIDTH+2.
- DONE:
  - out_sum = S and out_overflow = ovf, both registered and held stable while out_valid=1 && out_ready=0.
  - On out_ready: S, C and ovf are cleared to 0 and next state is ACCUM. in_ready returns to 1 one cycle after the result handshake.
- out_sum and out_overflow read 0 outside DONE.
- Boundaries:
  - Single-operand group (in_last on the first beat): out_sum = operand, overflow=0.
  - in_valid is ignored (not accepted) in RESOLVE and DONE; the upstream must hold its data.
  - Wrap-around: the result is mod 2^ACC_WIDTH with sticky overflow. Overflow is exact; the sum of all dropped carries is nonzero iff the true sum is >= 2^ACC_WIDTH.
  - out_ready asserted outside DONE has no effect.
  - rst_n low at any time, including mid-RESOLVE or in DONE, returns immediately to the reset values. The partial group is discarded.

Optional Feature:
- Macro: CSA_STREAM_ACC_COUNT_EN.
- Defined:
  - Adds output out_count, width ACC_WIDTH, holding the number of operands accepted in the current group (saturating at all-ones).
  - Valid with out_valid; reads 0 otherwise.
  - Cleared on reset and on the result handshake.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- WIDTH=4, ACC_WIDTH=8; stream 3, 5, 7, 15 with in_last on 15, out_ready=1 -> out_sum=0x1E, out_overflow=0, out_valid within 10 cycles of the last beat.
- Twenty operands of 15 (total 300) -> out_sum=0x2C (44), out_overflow=1. With COUNT_EN: out_count=20.
- Single operand 9 with in_last -> out_valid exactly 2 cycles after acceptance, out_sum=9, out_overflow=0.
- Group 1, 2 with out_ready held low 5 cycles in DONE -> out_sum=3 stable, in_ready=0 throughout. in_valid=1 with data 6 is not accepted until 1 cycle after the out_ready handshake.
- Group 15, 15, 15, 15 with in_valid toggling (gaps) -> out_sum=60. A following group of 1, 1 -> out_sum=2, confirming the accumulator is cleared.
- Assert rst_n low for 1 cycle during RESOLVE of group 255, 1 (ACC_WIDTH=8, WIDTH=8) -> all outputs return to reset values asynchronously. A new group 4, 4 -> out_sum=8, out_overflow=0.

Source files
------------

// File: rtl/csa_stream_accumulator.sv
// ---------------------------------------------------------------------------
// csa_stream_accumulator
//
// Sums a stream of unsigned operands with one 3:2 carry-save compression per
// accepted operand, so no full carry chain sits in the per-operand path.
// After the operand flagged "last" the redundant sum/carry pair is resolved to
// binary by repeated half-add passes. The result is then presented on an
// output valid/ready handshake.
//
// Parameters:
//   WIDTH      operand width in bits
//   ACC_WIDTH  accumulator / result width in bits (>= WIDTH)
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   in_valid      operand present
//   in_ready      block can accept an operand (ACCUM state)
//   in_data       operand, zero-extended to ACC_WIDTH
//   in_last       marks in_data as the final operand of the group
//   out_valid     result available
//   out_ready     consumer takes the result
//   out_sum       resolved sum modulo 2^ACC_WIDTH (0 when out_valid=0)
//   out_overflow  true sum exceeded 2^ACC_WIDTH-1 (0 when out_valid=0)
//   out_count     (only with CSA_STREAM_ACC_COUNT_EN) operands accepted in
//                 the group, saturating; 0 when out_valid=0
//
// Optional feature macro: CSA_STREAM_ACC_COUNT_EN
// ---------------------------------------------------------------------------
module csa_stream_accumulator #(
    parameter int WIDTH     = 4,
    parameter int ACC_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_sum,
`ifdef CSA_STREAM_ACC_COUNT_EN
    output logic                 out_overflow,
    output logic [ACC_WIDTH-1:0] out_count
`else
    output logic                 out_overflow
`endif
);

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        RESOLVE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t               state, state_next;

    // Redundant accumulator: c_reg is kept already shifted to its weight.
    logic [ACC_WIDTH-1:0] s_reg, s_next;
    logic [ACC_WIDTH-1:0] c_reg, c_next;
    logic                 ovf_reg, ovf_next;

    // Registered result stage, loaded during the first DONE cycle.
    logic [ACC_WIDTH-1:0] res_sum_reg, res_sum_next;
    logic                 res_ovf_reg, res_ovf_next;
    logic                 res_valid_reg, res_valid_next;

    logic [ACC_WIDTH-1:0] x_ext;
    logic [ACC_WIDTH-1:0] maj;
    logic [ACC_WIDTH-1:0] pair_carry;
    logic                 accept;
    logic                 take_result;

    assign x_ext       = ACC_WIDTH'(in_data);
    assign maj         = (s_reg & c_reg) | (s_reg & x_ext) | (c_reg & x_ext);
    assign pair_carry  = s_reg & c_reg;
    assign accept      = in_valid && in_ready;
    assign take_result = res_valid_reg && out_ready;

    // State and datapath registers; reset discards any partial group.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ACCUM;
            s_reg         <= '0;
            c_reg         <= '0;
            ovf_reg       <= 1'b0;
            res_sum_reg   <= '0;
            res_ovf_reg   <= 1'b0;
            res_valid_reg <= 1'b0;
        end else begin
            state         <= state_next;
            s_reg         <= s_next;
            c_reg         <= c_next;
            ovf_reg       <= ovf_next;
            res_sum_reg   <= res_sum_next;
            res_ovf_reg   <= res_ovf_next;
            res_valid_reg <= res_valid_next;
        end
    end

    // Next-state and datapath logic.
    // Any carry shifted out of the MSB is a dropped 2^ACC_WIDTH contribution,
    // so OR-ing those bits into ovf makes the overflow flag exact.
    always_comb begin
        state_next     = state;
        s_next         = s_reg;
        c_next         = c_reg;
        ovf_next       = ovf_reg;
        res_sum_next   = res_sum_reg;
        res_ovf_next   = res_ovf_reg;
        res_valid_next = res_valid_reg;

        case (state)
            ACCUM: begin
                if (accept) begin
                    s_next   = s_reg ^ c_reg ^ x_ext;
                    c_next   = maj << 1;
                    ovf_next = ovf_reg | maj[ACC_WIDTH-1];
                    if (in_last) begin
                        state_next = RESOLVE;
                    end
                end
            end

            RESOLVE: begin
                if (c_reg == '0) begin
                    state_next = DONE;
                end else begin
                    s_next   = s_reg ^ c_reg;
                    c_next   = pair_carry << 1;
                    ovf_next = ovf_reg | pair_carry[ACC_WIDTH-1];
                end
            end

            DONE: begin
                if (!res_valid_reg) begin
                    res_sum_next   = s_reg;
                    res_ovf_next   = ovf_reg;
                    res_valid_next = 1'b1;
                end else if (out_ready) begin
                    s_next         = '0;
                    c_next         = '0;
                    ovf_next       = 1'b0;
                    res_sum_next   = '0;
                    res_ovf_next   = 1'b0;
                    res_valid_next = 1'b0;
                    state_next     = ACCUM;
                end
            end

            default: begin
                state_next = ACCUM;
            end
        endcase
    end

    assign in_ready     = (state == ACCUM);
    assign out_valid    = res_valid_reg;
    assign out_sum      = res_sum_reg;
    assign out_overflow = res_ovf_reg;

`ifdef CSA_STREAM_ACC_COUNT_EN
    logic [ACC_WIDTH-1:0] count_reg, count_next;

    // Operand counter for the current group, saturating at all-ones.
    always_comb begin
        count_next = count_reg;
        if (take_result) begin
            count_next = '0;
        end else if (accept && (count_reg != {ACC_WIDTH{1'b1}})) begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign out_count = res_valid_reg ? count_reg : '0;
`else
    logic unused_take_result;
    assign unused_take_result = take_result;
`endif

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// ---------------------------------------------------------------------------
// tb_csa_stream_accumulator
//
// Directed test bench for csa_stream_accumulator (WIDTH=4, ACC_WIDTH=8).
// A behavioural model keeps the plain integer total of each group; a
// compare process checks the DUT outputs against it every cycle.
// ---------------------------------------------------------------------------
module tb_csa_stream_accumulator;

    localparam int WIDTH     = 4;
    localparam int ACC_WIDTH = 8;
    localparam int MAX_LAT   = ACC_WIDTH + 2;

    logic                 clk;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] out_sum;
    logic                 out_overflow;
`ifdef CSA_STREAM_ACC_COUNT_EN
    logic [ACC_WIDTH-1:0] out_count;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model state
    int  group_total = 0;
    int  group_count = 0;
    int  exp_sum     = 0;
    int  exp_ovf     = 0;
    int  exp_count   = 0;
    bit  pending     = 0;
    int  last_edge   = 0;
    bit  seen_valid  = 0;
    bit  timed_out   = 0;

    csa_stream_accumulator #(
        .WIDTH    (WIDTH),
        .ACC_WIDTH(ACC_WIDTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sum     (out_sum),
`ifdef CSA_STREAM_ACC_COUNT_EN
        .out_overflow(out_overflow),
        .out_count   (out_count)
`else
        .out_overflow(out_overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, actual, actual, expected, expected, cyc);
        end
    endtask

    // Offer one operand, wait for acceptance, then update the model.
    task automatic applyStimulus(input logic [WIDTH-1:0] d, input bit last, input int gap);
        bit rdy;
        bit accepted = 0;
        int tries = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!accepted && tries < 50) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) accepted = 1;
            tries++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!accepted) begin
            checkOutput("operand_accept_timeout", tries, 0);
        end else begin
            group_total += int'(d);
            if (group_count < 255) group_count++;
            if (last) begin
                exp_sum     = group_total % 256;
                exp_ovf     = (group_total > 255) ? 1 : 0;
                exp_count   = group_count;
                last_edge   = cyc;
                seen_valid  = 0;
                timed_out   = 0;
                pending     = 1;
                group_total = 0;
                group_count = 0;
            end
        end
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Wait (bounded) for out_valid and pin the result to literal values.
    task automatic waitResult(input int lit_sum, input int lit_ovf, output int lat);
        int n = 0;
        lat = -1;
        out_ready = 1'b0;
        while (n < 30) begin
            @(negedge clk);
            if (out_valid) break;
            n++;
        end
        if (!out_valid) begin
            checkOutput("result_wait_timeout", n, 0);
        end else begin
            lat = cyc - last_edge;
            checkOutput("literal_sum", int'(out_sum), lit_sum);
            checkOutput("literal_overflow", int'(out_overflow), lit_ovf);
        end
    endtask

    // Complete the result handshake (called at a negedge).
    task automatic releaseResult();
        out_ready = 1'b1;
        @(posedge clk);
        pending = 0;
        #1;
        out_ready = 1'b0;
    endtask

    // Compare process: check DUT outputs against the model every cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                checkOutput("valid_without_group", int'(out_valid), int'(pending));
                if (pending) begin
                    checkOutput("model_sum", int'(out_sum), exp_sum);
                    checkOutput("model_overflow", int'(out_overflow), exp_ovf);
                    checkOutput("in_ready_while_valid", int'(in_ready), 0);
`ifdef CSA_STREAM_ACC_COUNT_EN
                    checkOutput("model_count", int'(out_count), exp_count);
`endif
                    if (!seen_valid) begin
                        seen_valid = 1;
                        checkOutput("latency_in_range",
                                    ((cyc - last_edge) >= 2 && (cyc - last_edge) <= MAX_LAT) ? 1 : 0, 1);
                    end
                end
            end else begin
                checkOutput("idle_sum_zero", int'(out_sum), 0);
                checkOutput("idle_overflow_zero", int'(out_overflow), 0);
`ifdef CSA_STREAM_ACC_COUNT_EN
                checkOutput("idle_count_zero", int'(out_count), 0);
`endif
                if (pending && !timed_out && (cyc - last_edge) > MAX_LAT) begin
                    timed_out = 1;
                    checkOutput("latency_timeout", cyc - last_edge, MAX_LAT);
                end
            end
        end
    end

    initial begin
        int lat;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("reset_in_ready", int'(in_ready), 1);
        checkOutput("reset_out_valid", int'(out_valid), 0);
        checkOutput("reset_out_sum", int'(out_sum), 0);
        checkOutput("reset_out_overflow", int'(out_overflow), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 3+5+7+15 = 30
        $display("[TB] group 3,5,7,15");
        applyStimulus(4'd3, 0, 0);
        applyStimulus(4'd5, 0, 0);
        applyStimulus(4'd7, 0, 0);
        applyStimulus(4'd15, 1, 0);
        waitResult(8'h1E, 0, lat);
        releaseResult();

        // 20 x 15 = 300 -> 44 with overflow
        $display("[TB] group 20 x 15");
        for (int i = 0; i < 20; i++) applyStimulus(4'd15, (i == 19), 0);
        waitResult(8'h2C, 1, lat);
`ifdef CSA_STREAM_ACC_COUNT_EN
        checkOutput("literal_count_20", int'(out_count), 20);
`endif
        releaseResult();

        // Single operand: exactly 2 cycles to out_valid
        $display("[TB] single operand 9");
        applyStimulus(4'd9, 1, 0);
        waitResult(9, 0, lat);
        checkOutput("single_operand_latency", lat, 2);
        releaseResult();

        // Group 1,2 held in DONE; pending operand 6 waits for the handshake
        $display("[TB] group 1,2 with held result");
        applyStimulus(4'd1, 0, 0);
        applyStimulus(4'd2, 1, 0);
        waitResult(3, 0, lat);
        in_valid = 1'b1;
        in_data  = 4'd6;
        in_last  = 1'b1;
        repeat (5) begin
            @(negedge clk);
            checkOutput("held_in_ready", int'(in_ready), 0);
            checkOutput("held_out_valid", int'(out_valid), 1);
            checkOutput("held_out_sum", int'(out_sum), 3);
        end
        releaseResult();
        checkOutput("in_ready_after_handshake", int'(in_ready), 1);
        applyStimulus(4'd6, 1, 0);
        checkOutput("accept_one_cycle_after", cyc - last_edge, 0);
        waitResult(6, 0, lat);
        releaseResult();

        // Gapped group 4 x 15 = 60, then 1,1 = 2
        $display("[TB] gapped group 4 x 15 then 1,1");
        for (int i = 0; i < 4; i++) applyStimulus(4'd15, (i == 3), 2);
        waitResult(60, 0, lat);
        releaseResult();
        applyStimulus(4'd1, 0, 1);
        applyStimulus(4'd1, 1, 0);
        waitResult(2, 0, lat);
        releaseResult();

        // Reset in the middle of RESOLVE (15,1 needs several passes)
        $display("[TB] reset during RESOLVE");
        applyStimulus(4'd15, 0, 0);
        applyStimulus(4'd1, 1, 0);
        @(posedge clk);
        @(negedge clk);
        #3;
        pending = 0;
        rst_n   = 1'b0;
        #1;
        checkOutput("resolve_reset_in_ready", int'(in_ready), 1);
        checkOutput("resolve_reset_out_valid", int'(out_valid), 0);
        checkOutput("resolve_reset_out_sum", int'(out_sum), 0);
        checkOutput("resolve_reset_out_overflow", int'(out_overflow), 0);
        @(negedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(4'd4, 0, 0);
        applyStimulus(4'd4, 1, 0);
        waitResult(8, 0, lat);
        releaseResult();

        // Reset while a result is presented
        $display("[TB] reset during DONE");
        for (int i = 0; i < 18; i++) applyStimulus(4'd15, (i == 17), 0);
        waitResult(14, 1, lat);
        #3;
        pending = 0;
        rst_n   = 1'b0;
        #1;
        checkOutput("done_reset_out_valid", int'(out_valid), 0);
        checkOutput("done_reset_out_sum", int'(out_sum), 0);
        checkOutput("done_reset_out_overflow", int'(out_overflow), 0);
        checkOutput("done_reset_in_ready", int'(in_ready), 1);
        @(negedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(4'd7, 1, 0);
        waitResult(7, 0, lat);
        releaseResult();

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
